// File: rtl/mem_check_pkg.sv
// Shared types and constants for the data-memory write checker.
// State encoding, fail codes and the expected-write entry layout live here.
package mem_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    localparam logic [2:0] FC_NONE          = 3'd0;
    localparam logic [2:0] FC_UNEXP_ADDR    = 3'd1;
    localparam logic [2:0] FC_DATA_MISMATCH = 3'd2;
    localparam logic [2:0] FC_TIMEOUT       = 3'd3;

    localparam int EXP_ADDR_W = 32;
    localparam int EXP_DATA_W = 32;

    // Default-width view of one queue entry; address sits in the upper bits.
    typedef struct packed {
        logic [EXP_ADDR_W-1:0] addr;
        logic [EXP_DATA_W-1:0] data;
    } exp_entry_t;

endpackage

// File: rtl/mem_write_checker_exp_fifo.sv
// Circular-buffer FIFO holding expected writes; head shows the oldest entry.
// A count register tells full from empty; flush drops everything in one edge.
module exp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor for the CPU data-memory write port: matches writes
// against a queue of expected (addr, data), tolerates a scratch window, times out.
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_EXP     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    // exp_valid/exp_ready: an entry transfers on a rising edge where both are
    // high; exp_addr/exp_data must be stable while exp_valid is high, and the
    // offer may be held or withdrawn freely while exp_ready is low.
    input  logic                         exp_valid,
    input  logic [ADDR_W-1:0]            exp_addr,
    input  logic [DATA_W-1:0]            exp_data,
    output logic                         exp_ready,
    input  logic [ADDR_W-1:0]            ign_lo,
    input  logic [ADDR_W-1:0]            ign_hi,
    input  logic                         start,
    input  logic                         clear,
    input  logic                         memwrite,
    input  logic [ADDR_W-1:0]            dataadr,
    input  logic [DATA_W-1:0]            writedata,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [2:0]                   fail_code,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data,
    output logic [$clog2(NUM_EXP+1)-1:0] match_cnt,
    output logic [7:0]                   ign_cnt
);

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(NUM_EXP+1);
    localparam int CYC_W = $clog2(TIMEOUT_CYC);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYC-1);

    state_e           state;
    logic             rdy_en;
    logic [CYC_W-1:0] cyc;

    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    logic [ENT_W-1:0] q_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic wr_active;
    logic addr_hit;
    logic data_hit;
    logic in_win;
    logic ev_match;
    logic ev_last;
    logic ev_mismatch;
    logic ev_ign;
    logic ev_unexp;
    logic expire;

    assign head_addr = q_head[ENT_W-1:DATA_W];
    assign head_data = q_head[DATA_W-1:0];

    // rdy_en keeps exp_ready low through reset and until the first edge after it.
    assign exp_ready = rdy_en && (state == IDLE) && !q_full;
    assign q_push    = exp_valid && exp_ready;
    assign q_pop     = ev_match;

    assign busy = (state == RUN);
    assign done = (state == PASS) || (state == FAIL);
    assign pass = (state == PASS);

    exp_fifo #(
        .DEPTH (NUM_EXP),
        .WIDTH (ENT_W)
    ) u_exp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (clear),
        .push    (q_push),
        .din     ({exp_addr, exp_data}),
        .pop     (q_pop),
        .head    (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    // Classification priority: head match, head data mismatch, scratch, other.
    always_comb begin
        wr_active   = (state == RUN) && memwrite && !clear;
        addr_hit    = (dataadr == head_addr);
        data_hit    = (writedata == head_data);
        in_win      = (dataadr >= ign_lo) && (dataadr <= ign_hi);
        ev_match    = wr_active && addr_hit && data_hit;
        ev_last     = ev_match && (q_count == CNT_W'(1));
        ev_mismatch = wr_active && addr_hit && !data_hit;
        ev_ign      = wr_active && !addr_hit && in_win;
        ev_unexp    = wr_active && !addr_hit && !in_win;
        expire      = (state == RUN) && (cyc == CYC_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rdy_en    <= 1'b0;
            cyc       <= '0;
            match_cnt <= '0;
            ign_cnt   <= '0;
            fail_code <= FC_NONE;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (clear) begin
                state     <= IDLE;
                cyc       <= '0;
                match_cnt <= '0;
                ign_cnt   <= '0;
                fail_code <= FC_NONE;
                fail_addr <= '0;
                fail_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !q_empty) begin
                            state     <= RUN;
                            cyc       <= '0;
                            match_cnt <= '0;
                            ign_cnt   <= '0;
                        end
                    end
                    RUN: begin
                        if (ev_match) match_cnt <= match_cnt + CNT_W'(1);
                        if (ev_ign && (ign_cnt != 8'hFF)) ign_cnt <= ign_cnt + 8'd1;
                        // A terminal write in the expiry cycle outranks the timeout.
                        if (ev_last) begin
                            state <= PASS;
                        end else if (ev_mismatch || ev_unexp) begin
                            state     <= FAIL;
                            fail_code <= ev_mismatch ? FC_DATA_MISMATCH : FC_UNEXP_ADDR;
                            fail_addr <= dataadr;
                            fail_data <= writedata;
                        end else if (expire) begin
                            state     <= FAIL;
                            fail_code <= FC_TIMEOUT;
                            fail_addr <= '0;
                            fail_data <= '0;
                        end else begin
                            cyc <= cyc + CYC_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor for the multi-cycle MIPS data-memory write port. Replaces the fixed "7 written to address 84" testbench check.
- Holds a parametrised queue of expected (address, data) writes.
- Allows a programmable scratch address window to be written freely.
- Enforces a cycle timeout.
- Reports pass/fail with a fail code and the offending address and data, so the same check runs in simulation and on the FPGA board.

Parameters:
- ADDR_W, 32, width of dataadr.
- DATA_W, 32, width of writedata.
- NUM_EXP, 4, depth of the expected-write queue (>=1).
- TIMEOUT_CYC, 1024, RUN cycles allowed before a timeout failure (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- exp_valid  in  1  expected-write entry offered.
- exp_addr  in  ADDR_W  expected address.
- exp_data  in  DATA_W  expected data.
- exp_ready  out  1  entry accepted when exp_valid & exp_ready.
- ign_lo  in  ADDR_W  scratch window low bound, inclusive.
- ign_hi  in  ADDR_W  scratch window high bound, inclusive.
- start  in  1  pulse: begin checking.
- clear  in  1  pulse: flush and return to IDLE.
- memwrite  in  1  CPU memory write strobe.
- dataadr  in  ADDR_W  CPU write address.
- writedata  in  DATA_W  CPU write data.
- busy  out  1  state==RUN.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state==PASS.
- fail_code  out  3  0 none, 1 unexpected address, 2 data mismatch, 3 timeout.
- fail_addr  out  ADDR_W  address of the failing write (0 on timeout).
- fail_data  out  DATA_W  data of the failing write (0 on timeout).
- match_cnt  out  $clog2(NUM_EXP+1)  expected writes matched.
- ign_cnt  out  8  scratch writes seen, saturating at 255.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, queue empty, all outputs 0. exp_ready rises in the first cycle after release.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - exp_ready = !full. Queue is FIFO order; push on exp_valid & exp_ready.
  - start with queue non-empty -> RUN. Cycle counter and match/ign counts clear in the same edge.
  - start with queue empty is ignored.
  - memwrite is ignored.
- RUN: exp_ready=0. Each rising edge with memwrite=1 classifies the write against the queue head, in priority order:
  - dataadr==head.addr and writedata==head.data: pop the head, match_cnt+1. If it was the last entry -> PASS on the same edge.
  - dataadr==head.addr, data differs -> FAIL, code 2.
  - ign_lo <= dataadr <= ign_hi (unsigned): ign_cnt+1, stay in RUN.
  - otherwise -> FAIL, code 1.
  - Head match takes priority over the ignore window when both apply.
- Timeout:
  - Cycle counter increments every RUN cycle.
  - When the counter reaches TIMEOUT_CYC-1 with no terminal event in that cycle -> FAIL, code 3.
  - A matching final write in the expiry cycle wins: PASS.
- PASS/FAIL:
  - Sticky. memwrite and start are ignored.
  - fail_addr/fail_data are captured on the failing edge.
  - All outputs are registered, valid the cycle after the deciding edge.
- clear: from any state -> IDLE on the next edge. Queue flushed; counters, fail fields and pass clear. clear has priority over start and over memwrite classification in the same cycle.
- exp_valid during RUN/PASS/FAIL: not accepted, no side effect.
- Queue: NUM_EXP-entry circular buffer with wrapping read/write pointers. The count register distinguishes full from empty.
- Widths: the cycle counter is $clog2(TIMEOUT_CYC) bits and never wraps, because it stops at expiry.

Decomposition:
- Package mem_check_pkg holds:
  - state enum (IDLE, RUN, PASS, FAIL);
  - fail_code constants FC_NONE=0, FC_UNEXP_ADDR=1, FC_DATA_MISMATCH=2, FC_TIMEOUT=3;
  - exp_entry_t struct {addr, data}, parametrised via localparams.
- One sub-module: exp_fifo, a synchronous FIFO with push/pop/full/empty/head and parameters DEPTH, WIDTH. It uses the same clk/reset_n and has no bypass.

Test Plan:
- Load (84,7), ignore 80..80, start; writes (80,x) then (84,7) -> ign_cnt=1, match_cnt=1, pass=1, fail_code=0.
- Load (84,7), start; write (88,5) -> FAIL, fail_code=1, fail_addr=88, fail_data=5, pass=0.
- Load (84,7), start; write (84,6) -> FAIL, fail_code=2, fail_addr=84, fail_data=6.
- TIMEOUT_CYC=16, load (84,7), start, no writes -> done=1, fail_code=3 exactly 16 cycles after start. A write (84,7) on the 16th RUN cycle instead -> pass=1.
- Queue ordering and full:
  - Offer 5 entries (0,1),(4,2),(8,3),(12,4),(16,5) -> exp_ready low after the 4th, 5th not accepted.
  - Writes (0,1),(4,2),(8,3),(12,4) -> pass with match_cnt=4.
  - Order (4,2) first -> fail_code=1.
- Load 2 entries, start, match 1, assert reset_n low mid-RUN -> immediate IDLE, match_cnt=0, queue empty, exp_ready=1 the cycle after release. clear from FAIL -> IDLE with fail_code=0.
